chk_fifo: RTL and testbench

Parametrised successor to the single-mode parity FIFO: a synchronous first-word-fall-through FIFO with a valid/grant handshake on both sides, any depth ≥ 2 (not limited to powers of two), and parity checking selectable between off, flag mode and drop mode. It adds an occupancy count, almost-full/almost-empty thresholds and a saturating counter of corrupt words. It sits between a producer using `valid_i`/`grant_o` and a consumer using `valid_o`/`grant_i`.

---
 rtl/chk_fifo_pkg.sv | 21 ++
 rtl/chk_fifo_ram.sv | 24 ++
 rtl/chk_fifo.sv | 106 ++++++++++
 tb/tb_chk_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/chk_fifo_pkg.sv
// chk_fifo shared definitions.
// Parity helper and counter widths.
package chk_fifo_pkg;

  localparam int PAR_MAX_W = 1024;
  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Words narrower than PAR_MAX_W are zero-extended; zeros leave XOR intact.
  function automatic logic parity_ok(
    input logic [PAR_MAX_W-1:0] word,
    input logic                 even_odd
  );
    return (^word) == even_odd;
  endfunction

endpackage

// File: rtl/chk_fifo_ram.sv
// chk_fifo storage: word plus err bit.
// Synchronous write, asynchronous read, no reset.
module chk_fifo_ram #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chk_fifo.sv
// First-word-fall-through FIFO with parity check,
// occupancy thresholds and saturating corrupt-word counter.
module chk_fifo
  import chk_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  bit PARITY_EN  = 1'b1,
  parameter  bit EVEN_ODD   = 1'b0,
  parameter  bit DROP_MODE  = 1'b1,
  parameter  int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter  int AE_LEVEL   = 1,
  localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic                  err_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DROP_W-1:0]     drop_cnt_o,
  input  logic                  clr_cnt_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WW    = DATA_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nx;
  logic              grant_q;
  logic [DROP_W-1:0] drop_cnt;
  logic [WW:0]       rd_entry;
  logic              good;
  logic              push;
  logic              pop;
  logic              store;
  logic              corrupt;

  assign good    = !PARITY_EN ||
                   parity_ok(PAR_MAX_W'(data_i), EVEN_ODD);
  assign push    = valid_i && grant_q;
  assign pop     = valid_o && grant_i;
  assign store   = push && (good || !DROP_MODE);
  assign corrupt = push && !good;

  always_comb begin
    count_nx = count + CNT_W'(store) - CNT_W'(pop);
  end

  chk_fifo_ram #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata ({!good, data_i}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      grant_q  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (store) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count   <= count_nx;
      // Registered so grant stays low through reset and has no input path.
      grant_q <= (count_nx != FULL_C);
      if (clr_cnt_i) begin
        drop_cnt <= '0;
      end else if (corrupt && drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  assign valid_o        = (count != '0);
  assign grant_o        = grant_q;
  assign data_o         = valid_o ? rd_entry[WW-1:0] : '0;
  assign err_o          = valid_o && rd_entry[WW] && !DROP_MODE;
  assign count_o        = count;
  assign almost_full_o  = int'(count) >= AF_LEVEL;
  assign almost_empty_o = int'(count) <= AE_LEVEL;
  assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_chk_fifo.sv
// Directed bench for chk_fifo: drop mode, flag mode,
// non-power-of-two depth wrap and asynchronous reset.
module tb_chk_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  data;
  logic [2:0]  vi;
  logic [2:0]  gi;
  logic        clr;

  logic [8:0]  dout [3];
  logic        vo   [3];
  logic        go   [3];
  logic        eo   [3];
  logic        af   [3];
  logic        ae   [3];
  logic [2:0]  cnt  [3];
  logic [15:0] dc   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chk_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DROP_MODE(1'b1)) u_drop (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(vi[0]),
    .grant_o(go[0]), .data_o(dout[0]), .valid_o(vo[0]),
    .grant_i(gi[0]), .err_o(eo[0]), .count_o(cnt[0]),
    .almost_full_o(af[0]), .almost_empty_o(ae[0]),
    .drop_cnt_o(dc[0]), .clr_cnt_i(clr)
  );

  chk_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DROP_MODE(1'b0)) u_flag (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(vi[1]),
    .grant_o(go[1]), .data_o(dout[1]), .valid_o(vo[1]),
    .grant_i(gi[1]), .err_o(eo[1]), .count_o(cnt[1]),
    .almost_full_o(af[1]), .almost_empty_o(ae[1]),
    .drop_cnt_o(dc[1]), .clr_cnt_i(clr)
  );

  chk_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .DROP_MODE(1'b1)) u_d5 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(vi[2]),
    .grant_o(go[2]), .data_o(dout[2]), .valid_o(vo[2]),
    .grant_i(gi[2]), .err_o(eo[2]), .count_o(cnt[2]),
    .almost_full_o(af[2]), .almost_empty_o(ae[2]),
    .drop_cnt_o(dc[2]), .clr_cnt_i(clr)
  );

  // Even parity: good word has overall XOR 0, bad word has XOR 1.
  function automatic logic [8:0] gw(input logic [7:0] d);
    return {^d, d};
  endfunction

  function automatic logic [8:0] bw(input logic [7:0] d);
    return {~^d, d};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    data = '0;
    vi   = '0;
    gi   = '0;
    clr  = 1'b0;
    #12;
    chk("rst_valid", 32'(vo[0]), 0);
    chk("rst_data", 32'(dout[0]), 0);
    chk("rst_err", 32'(eo[0]), 0);
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_ae", 32'(ae[0]), 1);
    chk("rst_af", 32'(af[0]), 0);
    chk("rst_grant", 32'(go[0]), 0);
    chk("rst_drop", 32'(dc[0]), 0);
    tick;
    rst = 1'b0;
    chk("grant_at_release", 32'(go[0]), 0);
    tick;
    chk("grant_after_edge", 32'(go[0]), 1);

    // Fill depth-4 with 6 good words; only 4 fit.
    for (int i = 0; i < 6; i++) begin
      data  = gw(8'(2 * (i + 1)));
      vi[0] = 1'b1;
      tick;
      if (i == 2) chk("fill3_grant", 32'(go[0]), 1);
      if (i == 3) chk("full_grant", 32'(go[0]), 0);
    end
    vi[0] = 1'b0;
    chk("full_count", 32'(cnt[0]), 4);
    chk("full_af", 32'(af[0]), 1);
    chk("full_ae", 32'(ae[0]), 0);
    chk("full_head", 32'(dout[0]), 32'(gw(8'h02)));

    // Drain with grant held for 6 cycles.
    gi[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        chk("pop_valid", 32'(vo[0]), 1);
        chk("pop_data", 32'(dout[0]), 32'(gw(8'(2 * (i + 1)))));
      end
      tick;
    end
    gi[0] = 1'b0;
    chk("empty_valid", 32'(vo[0]), 0);
    chk("empty_count", 32'(cnt[0]), 0);
    chk("empty_ae", 32'(ae[0]), 1);
    chk("empty_data", 32'(dout[0]), 0);
    chk("empty_grant", 32'(go[0]), 1);

    // Pointers must not have moved on the extra grants.
    data  = gw(8'h0E);
    vi[0] = 1'b1;
    tick;
    vi[0] = 1'b0;
    chk("ptr_head", 32'(dout[0]), 32'(gw(8'h0E)));
    chk("ptr_count", 32'(cnt[0]), 1);
    gi[0] = 1'b1;
    tick;
    gi[0] = 1'b0;
    chk("ptr_drain", 32'(cnt[0]), 0);

    // Drop mode: two corrupt words discarded.
    vi[0] = 1'b1;
    data  = bw(8'h03);
    tick;
    chk("drop1_cnt", 32'(dc[0]), 1);
    chk("drop1_valid", 32'(vo[0]), 0);
    data  = bw(8'h05);
    tick;
    data  = gw(8'h06);
    tick;
    vi[0] = 1'b0;
    chk("drop_count", 32'(cnt[0]), 1);
    chk("drop_cnt", 32'(dc[0]), 2);
    chk("drop_head", 32'(dout[0]), 32'(gw(8'h06)));
    chk("drop_err", 32'(eo[0]), 0);

    // Flag mode: corrupt word stored with err set.
    data  = bw(8'h03);
    vi[1] = 1'b1;
    tick;
    data  = gw(8'h06);
    chk("flag_head", 32'(dout[1]), 32'(bw(8'h03)));
    chk("flag_err", 32'(eo[1]), 1);
    chk("flag_drop", 32'(dc[1]), 1);
    tick;
    vi[1] = 1'b0;
    chk("flag_count", 32'(cnt[1]), 2);
    gi[1] = 1'b1;
    tick;
    gi[1] = 1'b0;
    chk("flag_head2", 32'(dout[1]), 32'(gw(8'h06)));
    chk("flag_err2", 32'(eo[1]), 0);
    chk("flag_drop2", 32'(dc[1]), 1);

    // Depth 5: preload 2 then stream push+pop across the wrap.
    data  = gw(8'h02);
    vi[2] = 1'b1;
    tick;
    data  = gw(8'h04);
    tick;
    chk("d5_pre_count", 32'(cnt[2]), 2);
    gi[2] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      data = gw(8'(2 * (j + 3)));
      chk("d5_head", 32'(dout[2]), 32'(gw(8'(2 * (j + 1)))));
      chk("d5_count", 32'(cnt[2]), 2);
      tick;
    end
    chk("d5_final_head", 32'(dout[2]), 32'(gw(8'd42)));
    gi[2] = 1'b0;
    data  = gw(8'd46);
    tick;
    vi[2] = 1'b0;
    chk("d5_count3", 32'(cnt[2]), 3);

    // Asynchronous reset in the middle of a cycle.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(cnt[2]), 0);
    chk("arst_valid", 32'(vo[2]), 0);
    chk("arst_data", 32'(dout[2]), 0);
    chk("arst_grant", 32'(go[2]), 0);
    chk("arst_ae", 32'(ae[2]), 1);
    chk("arst_af", 32'(af[2]), 0);
    chk("arst_drop", 32'(dc[0]), 0);
    tick;
    rst = 1'b0;
    chk("arst_grant_rel", 32'(go[2]), 0);
    tick;
    chk("arst_grant_up", 32'(go[2]), 1);

    // Clear wins over a same-cycle drop.
    data  = bw(8'h03);
    vi[0] = 1'b1;
    tick;
    chk("clr_pre", 32'(dc[0]), 1);
    data  = bw(8'h05);
    clr   = 1'b1;
    tick;
    vi[0] = 1'b0;
    clr   = 1'b0;
    chk("clr_drop", 32'(dc[0]), 0);
    chk("clr_count", 32'(cnt[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
